// File: rtl/serial_number_transmitter.sv
// Parallel-to-serial word source, MSB-first, with a running prefix-remainder
// flag that gives a downstream divisibility checker a golden reference.
module serial_number_transmitter #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             new_bit,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             last_bit,
  output logic             prefix_div
);

  localparam int RW = $clog2(DIVISOR);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [RW:0]   DIV_C    = (RW + 1)'(DIVISOR);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic [RW-1:0]    rem;

  logic [RW:0]      dbl;
  logic [RW-1:0]    rem_next;
  logic             take_bit;
  logic             take_word;

  // 2*rem + bit never exceeds 2*DIVISOR-1, so one conditional subtract reduces it.
  always_comb begin
    dbl = {rem, shreg[WIDTH-1]};
    if (dbl >= DIV_C) begin
      rem_next = RW'(dbl - DIV_C);
    end else begin
      rem_next = dbl[RW-1:0];
    end
  end

  assign bit_valid  = (state == SEND);
  assign new_bit    = bit_valid & shreg[WIDTH-1];
  assign last_bit   = bit_valid & (count == '0);
  assign prefix_div = bit_valid & (rem_next == '0);
  assign take_bit   = bit_valid & bit_ready;
  // Accepting on the final bit transfer lets the next word follow with no bubble.
  assign up_ready   = (state == IDLE) | (last_bit & bit_ready);
  assign take_word  = up_valid & up_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
      rem   <= '0;
    end else if (take_word) begin
      state <= SEND;
      shreg <= up_data;
      count <= LAST_IDX;
      rem   <= '0;
    end else if (take_bit) begin
      if (last_bit) begin
        state <= IDLE;
      end else begin
        shreg <= shreg << 1;
        count <= count - 1'b1;
        rem   <= rem_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_number_transmitter.sv
// Randomized self-checking bench; expectations come from arithmetic on the
// transmitted prefix value rather than from a bit-serial recurrence.
module tb_serial_number_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid, up_ready, new_bit, bit_valid, bit_ready, last_bit, prefix_div;
  logic [7:0] up_data;
  logic       up_valid1, up_ready1, new_bit1, bit_valid1, bit_ready1, last_bit1, prefix_div1;
  logic [0:0] up_data1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_number_transmitter #(.WIDTH(8), .DIVISOR(5)) dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .new_bit(new_bit), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .last_bit(last_bit), .prefix_div(prefix_div)
  );

  serial_number_transmitter #(.WIDTH(1), .DIVISOR(3)) dut1 (
    .clk(clk), .rst(rst), .up_valid(up_valid1), .up_ready(up_ready1), .up_data(up_data1),
    .new_bit(new_bit1), .bit_valid(bit_valid1), .bit_ready(bit_ready1),
    .last_bit(last_bit1), .prefix_div(prefix_div1)
  );

  // Bit i (0 = first sent) of a width-bit word.
  function automatic logic exp_bit(input int unsigned w, input int width, input int i);
    int unsigned s;
    s = w >> (width - 1 - i);
    return s[0];
  endfunction

  // The prefix after i+1 bits is simply the word's top i+1 bits as a number.
  function automatic logic exp_div(input int unsigned w, input int width, input int i, input int d);
    int unsigned prefix;
    prefix = w >> (width - 1 - i);
    return (prefix % d) == 0;
  endfunction

  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    got = {up_ready, bit_valid, new_bit, last_bit, prefix_div};
    n_checks++;
    if (got !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 10000 (ready,valid,bit,last,div)", got);
    end
    got = {up_ready1, bit_valid1, new_bit1, last_bit1, prefix_div1};
    n_checks++;
    if (got !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_outputs_w1: got %b expected 10000", got);
    end
    @(negedge clk);
    rst = 1'b1;
    $display("reset released");
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic test_word(input logic [7:0] w, input int mode, input string name);
    logic [3:0] got, exp;
    int idx, cycles;
    logic final_flag;
    @(negedge clk);
    up_valid = 1'b1; up_data = w; bit_ready = 1'b0;
    #1;
    n_checks++;
    if (up_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready: got %b expected 1", name, up_ready);
    end
    @(negedge clk);
    up_valid = 1'b0; up_data = 8'($urandom);
    idx = 0; cycles = 0; final_flag = 1'b0;
    while (idx < 8 && cycles < 200) begin
      case (mode)
        0: bit_ready = 1'b1;
        1: bit_ready = (cycles % 3 == 0);
        default: bit_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      got = {bit_valid, new_bit, last_bit, prefix_div};
      exp = {1'b1, exp_bit(w, 8, idx), (idx == 7), exp_div(w, 8, idx, 5)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s bit%0d: got %b expected %b (valid,bit,last,div)", name, idx, got, exp);
      end
      if (idx == 7) begin
        n_checks++;
        if (up_ready !== bit_ready) begin
          n_fail++;
          $display("FAIL %s last_ready: got %b expected %b", name, up_ready, bit_ready);
        end
        final_flag = prefix_div;
      end
      if (bit_ready) idx++;
      @(negedge clk);
      up_data = 8'($urandom);
      cycles++;
    end
    n_checks++;
    if (idx != 8) begin
      n_fail++;
      $display("FAIL %s transfers: got %0d expected 8 within 200 cycles", name, idx);
    end
    n_checks++;
    if (final_flag !== (w % 5 == 0)) begin
      n_fail++;
      $display("FAIL %s final_flag: got %b expected %b", name, final_flag, (w % 5 == 0));
    end
    bit_ready = 1'b0;
    #1;
    n_checks++;
    if ({bit_valid, up_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got valid,ready=%b expected 01", name, {bit_valid, up_ready});
    end
    $display("word %02h (%s) sent in %0d cycles, final prefix_div=%b", w, name, cycles, final_flag);
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [2];
    logic [3:0] got, exp;
    words[0] = 8'hFF; words[1] = 8'h00;
    @(negedge clk);
    up_valid = 1'b1; up_data = words[0]; bit_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) up_data = words[1];
      if (i == 8) begin up_valid = 1'b0; up_data = 8'($urandom); end
      #1;
      got = {bit_valid, new_bit, last_bit, prefix_div};
      exp = {1'b1, exp_bit(words[i / 8], 8, i % 8), (i % 8 == 7), exp_div(words[i / 8], 8, i % 8, 5)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b bit%0d: got %b expected %b (valid,bit,last,div)", i, got, exp);
      end
      n_checks++;
      if (up_ready !== (i % 8 == 7)) begin
        n_fail++;
        $display("FAIL b2b up_ready%0d: got %b expected %b", i, up_ready, (i % 8 == 7));
      end
    end
    @(negedge clk);
    bit_ready = 1'b0;
    #1;
    n_checks++;
    if (bit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b end_valid: got %b expected 0", bit_valid);
    end
    $display("back-to-back words ff,00 sent");
  endtask

  task automatic test_async_reset();
    logic [4:0] got;
    @(negedge clk);
    up_valid = 1'b1; up_data = 8'hC3; bit_ready = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    repeat (3) @(negedge clk);
    bit_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    got = {up_ready, bit_valid, new_bit, last_bit, prefix_div};
    n_checks++;
    if (got !== 5'b10000) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 10000 (ready,valid,bit,last,div)", got);
    end
    @(negedge clk);
    rst = 1'b1;
    $display("word c3 aborted by reset after 3 bits");
    test_word(8'h05, 0, "after_reset");
  endtask

  task automatic test_width1();
    logic [3:0] got, exp;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      up_valid1 = 1'b1; up_data1 = 1'(w); bit_ready1 = 1'b1;
      @(negedge clk);
      up_valid1 = 1'b0; up_data1 = ~1'(w);
      #1;
      got = {bit_valid1, new_bit1, last_bit1, prefix_div1};
      exp = {1'b1, exp_bit(w, 1, 0), 1'b1, exp_div(w, 1, 0, 3)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL w1_word%0d: got %b expected %b (valid,bit,last,div)", w, got, exp);
      end
      @(negedge clk);
      bit_ready1 = 1'b0;
      #1;
      n_checks++;
      if (bit_valid1 !== 1'b0) begin
        n_fail++;
        $display("FAIL w1_idle%0d: got %b expected 0", w, bit_valid1);
      end
      $display("width-1 word %0d sent", w);
    end
  endtask

  task automatic test_loopback();
    for (int v = 0; v < 256; v++) begin
      test_word(8'(v), 2, "sweep");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    up_valid = 1'b0; up_data = '0; bit_ready = 1'b0;
    up_valid1 = 1'b0; up_data1 = '0; bit_ready1 = 1'b0;
    test_reset();
    test_word(8'hA5, 0, "a5");
    test_back_to_back();
    test_word(8'h0F, 1, "stall_0f");
    test_async_reset();
    test_width1();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
